// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the unified memory port arbiter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } arb_state_e;

    localparam logic OWNER_I = 1'b0;
    localparam logic OWNER_D = 1'b1;

    localparam int CNT_W = 4;

    // Round robin only matters on a conflict; a lone requester always wins.
    function automatic logic rr_pick(input logic ireq, input logic dreq, input logic last_gnt);
        if (ireq && dreq) begin
            return ~last_gnt;
        end
        if (dreq) begin
            return OWNER_D;
        end
        return OWNER_I;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - IF/MEM request, memory control and response signals of the arbiter
interface mem_port_arbiter_if;
    logic        IReq;
    logic        DReq;
    logic        DWrite;
    logic [31:0] MemRdData;
    logic        AddrSel;
    logic        MemEn;
    logic        MemWe;
    logic        IAck;
    logic        DAck;
    logic [31:0] RdData;
    logic        IStall;
    logic        DStall;

    modport slave (
        input  IReq, DReq, DWrite, MemRdData,
        output AddrSel, MemEn, MemWe, IAck, DAck, RdData, IStall, DStall
    );

    modport master (
        output IReq, DReq, DWrite, MemRdData,
        input  AddrSel, MemEn, MemWe, IAck, DAck, RdData, IStall, DStall
    );
endinterface

// File: rtl/mem_arb_latency_counter.sv
// rtl/mem_arb_latency_counter.sv - loadable down-counter that flags the last wait cycle
module mem_arb_latency_counter
    import mem_arb_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             term_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign term_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - grants the single-port memory to IF or MEM and sequences its read latency
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int LATENCY = 2
) (
    input  logic               Clk,
    input  logic               Rst,
    mem_port_arbiter_if.slave  bus
);

    arb_state_e  state_q;
    logic        owner_q;
    logic        last_gnt_q;
    logic        wr_q;
    logic        iack_q;
    logic        dack_q;
    logic [31:0] rddata_q;
    logic        cnt_term;

    mem_arb_latency_counter u_lat_cnt (
        .clk_i      (Clk),
        .rst_i      (Rst),
        .load_i     (state_q == ACCESS),
        .load_val_i (CNT_W'(LATENCY - 1)),
        .dec_i      (state_q == WAIT),
        .term_o     (cnt_term)
    );

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q    <= IDLE;
            owner_q    <= OWNER_I;
            last_gnt_q <= OWNER_D;
            wr_q       <= 1'b0;
            iack_q     <= 1'b0;
            dack_q     <= 1'b0;
            rddata_q   <= '0;
        end else begin
            iack_q <= 1'b0;
            dack_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.IReq || bus.DReq) begin
                        owner_q <= rr_pick(bus.IReq, bus.DReq, last_gnt_q);
                        state_q <= ACCESS;
                    end
                end
                ACCESS: begin
                    // Remember the direction so RESP knows whether to capture read data.
                    wr_q    <= (owner_q == OWNER_D) && bus.DWrite;
                    state_q <= (LATENCY == 1) ? RESP : WAIT;
                end
                WAIT: begin
                    if (cnt_term) begin
                        state_q <= RESP;
                    end
                end
                RESP: begin
                    if (!wr_q) begin
                        rddata_q <= bus.MemRdData;
                    end
                    if (owner_q == OWNER_D) begin
                        dack_q <= 1'b1;
                    end else begin
                        iack_q <= 1'b1;
                    end
                    last_gnt_q <= owner_q;
                    state_q    <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.AddrSel = owner_q;
    assign bus.MemEn   = (state_q == ACCESS);
    assign bus.MemWe   = (state_q == ACCESS) && (owner_q == OWNER_D) && bus.DWrite;
    assign bus.IAck    = iack_q;
    assign bus.DAck    = dack_q;
    assign bus.RdData  = rddata_q;
    assign bus.IStall  = bus.IReq & ~iack_q;
    assign bus.DStall  = bus.DReq & ~dack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter at LATENCY 2 and 1
module tb_mem_port_arbiter;

    logic Clk = 1'b0;
    logic Rst_a;
    logic Rst_b;

    always #5 Clk = ~Clk;

    mem_port_arbiter_if a ();
    mem_port_arbiter_if b ();

    mem_port_arbiter #(.LATENCY(2)) dut_a (.Clk(Clk), .Rst(Rst_a), .bus(a.slave));
    mem_port_arbiter #(.LATENCY(1)) dut_b (.Clk(Clk), .Rst(Rst_b), .bus(b.slave));

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Flag order: MemEn, MemWe, AddrSel, IAck, DAck
    task automatic chk_a(input string tag, input logic [4:0] exp);
        check_eq(tag, {27'd0, a.MemEn, a.MemWe, a.AddrSel, a.IAck, a.DAck}, {27'd0, exp});
    endtask

    task automatic chk_b(input string tag, input logic [4:0] exp);
        check_eq(tag, {27'd0, b.MemEn, b.MemWe, b.AddrSel, b.IAck, b.DAck}, {27'd0, exp});
    endtask

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        Rst_a = 1'b1; Rst_b = 1'b1;
        a.IReq = 1'b1; a.DReq = 1'b1; a.DWrite = 1'b0; a.MemRdData = 32'hDEADBEEF;
        b.IReq = 1'b0; b.DReq = 1'b0; b.DWrite = 1'b0; b.MemRdData = 32'hDEADBEEF;

        // Reset held two edges with both requests asserted
        cyc(); #1;
        chk_a("rst_flags", 5'b00000);
        check_eq("rst_rddata", a.RdData, 32'h0);
        cyc(); Rst_a = 1'b0; Rst_b = 1'b0; #1;
        chk_a("cf_c0", 5'b00000);
        check_eq("cf_c0_istall", {31'd0, a.IStall}, 32'd1);

        // Conflict: IF first, then MEM, then IF again
        cyc(); #1; chk_a("cf_c1", 5'b10000);
        cyc(); #1; chk_a("cf_c2", 5'b00000);
        cyc(); a.MemRdData = 32'hAAAA0003; #1; chk_a("cf_c3", 5'b00000);
        cyc(); a.MemRdData = 32'hDEADBEEF; #1;
        chk_a("cf_c4", 5'b00010);
        check_eq("cf_c4_rd", a.RdData, 32'hAAAA0003);
        check_eq("cf_c4_stall", {30'd0, a.IStall, a.DStall}, 32'd1);
        cyc(); #1; chk_a("cf_c5", 5'b10100);
        cyc(); #1; chk_a("cf_c6", 5'b00100);
        cyc(); a.MemRdData = 32'hBBBB0007; #1; chk_a("cf_c7", 5'b00100);
        cyc(); a.MemRdData = 32'hDEADBEEF; #1;
        chk_a("cf_c8", 5'b00101);
        check_eq("cf_c8_rd", a.RdData, 32'hBBBB0007);
        check_eq("cf_c8_stall", {30'd0, a.IStall, a.DStall}, 32'd2);
        // IF regranted; both requests then drop while the fetch is in flight
        cyc(); a.DReq = 1'b0; a.IReq = 1'b0; #1; chk_a("cf_c9", 5'b10000);
        cyc(); #1; chk_a("cf_c10", 5'b00000);
        cyc(); a.MemRdData = 32'hCCCC0011; #1; chk_a("cf_c11", 5'b00000);
        cyc(); a.MemRdData = 32'hDEADBEEF; #1;
        chk_a("cf_c12", 5'b00010);
        check_eq("cf_c12_rd", a.RdData, 32'hCCCC0011);

        // Single fetch
        cyc(); a.IReq = 1'b1; #1;
        chk_a("f_c0", 5'b00000);
        check_eq("f_c0_istall", {31'd0, a.IStall}, 32'd1);
        cyc(); #1; chk_a("f_c1", 5'b10000);
        check_eq("f_c1_istall", {31'd0, a.IStall}, 32'd1);
        cyc(); #1; chk_a("f_c2", 5'b00000);
        cyc(); a.MemRdData = 32'h8C010004; #1; chk_a("f_c3", 5'b00000);
        check_eq("f_c3_istall", {31'd0, a.IStall}, 32'd1);
        cyc(); a.IReq = 1'b0; a.MemRdData = 32'hDEADBEEF; #1;
        chk_a("f_c4", 5'b00010);
        check_eq("f_c4_rd", a.RdData, 32'h8C010004);

        // Store: write enable only in ACCESS, RdData untouched
        cyc(); a.DReq = 1'b1; a.DWrite = 1'b1; #1;
        chk_a("s_c0", 5'b00000);
        check_eq("s_c0_dstall", {31'd0, a.DStall}, 32'd1);
        cyc(); #1; chk_a("s_c1", 5'b11100);
        cyc(); #1; chk_a("s_c2", 5'b00100);
        cyc(); a.MemRdData = 32'hFFFFFFFF; #1; chk_a("s_c3", 5'b00100);
        cyc(); a.DReq = 1'b0; a.DWrite = 1'b0; a.MemRdData = 32'hDEADBEEF; #1;
        chk_a("s_c4", 5'b00101);
        check_eq("s_c4_rd", a.RdData, 32'h8C010004);

        // Reset during WAIT of a data read aborts it; reissued fetch completes
        cyc(); a.DReq = 1'b1; #1; chk_a("r_c0", 5'b00100);
        cyc(); #1; chk_a("r_c1", 5'b10100);
        cyc(); Rst_a = 1'b1; #1; chk_a("r_c2", 5'b00100);
        cyc(); Rst_a = 1'b0; a.DReq = 1'b0; a.IReq = 1'b1; #1;
        chk_a("r_c3", 5'b00000);
        check_eq("r_c3_rd", a.RdData, 32'h0);
        cyc(); #1; chk_a("r_c4", 5'b10000);
        cyc(); #1; chk_a("r_c5", 5'b00000);
        cyc(); a.MemRdData = 32'h11112222; #1; chk_a("r_c6", 5'b00000);
        cyc(); a.IReq = 1'b0; a.MemRdData = 32'hDEADBEEF; #1;
        chk_a("r_c7", 5'b00010);
        check_eq("r_c7_rd", a.RdData, 32'h11112222);

        // LATENCY 1 instance
        cyc(); b.IReq = 1'b1; #1; chk_b("l1_c0", 5'b00000);
        cyc(); #1; chk_b("l1_c1", 5'b10000);
        cyc(); b.MemRdData = 32'h00C0FFEE; #1; chk_b("l1_c2", 5'b00000);
        cyc(); b.IReq = 1'b0; b.MemRdData = 32'hDEADBEEF; #1;
        chk_b("l1_c3", 5'b00010);
        check_eq("l1_c3_rd", b.RdData, 32'h00C0FFEE);
        cyc(); #1; chk_b("l1_c4", 5'b00000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single-port unified memory between instruction fetch (IF) and data access (MEM) in the MIPS pipeline. It grants one requester at a time, drives the select of the 32-bit 2:1 address mux (0 = instruction address, 1 = data address), and sequences the memory's fixed read latency. It returns registered read data with a one-cycle acknowledge, and stalls the losing stage.

## Interface
- LATENCY, 2, memory read latency in cycles from the MemEn cycle to valid MemRdData; legal range 1..15
- Clk  in  1  clock; all logic on rising edge
- Rst  in  1  synchronous, active-high reset
- IReq  in  1  fetch request; level, held until IAck
- DReq  in  1  data request; level, held until DAck
- DWrite  in  1  data request is a store; sampled in ACCESS
- MemRdData  in  32  memory read data, valid in RESP
- AddrSel  out  1  address/write-data mux select; 0 = IF, 1 = MEM
- MemEn  out  1  memory enable, one cycle per transaction
- MemWe  out  1  memory write enable
- IAck  out  1  one-cycle completion pulse to IF
- DAck  out  1  one-cycle completion pulse to MEM
- RdData  out  32  registered read data
- IStall  out  1  IReq & ~IAck (combinational)
- DStall  out  1  DReq & ~DAck (combinational)

## Operation
- FSM states: IDLE, ACCESS, WAIT, RESP. Owner register: 0 = IF, 1 = MEM. LastGnt register.
- IDLE: no request → stay in IDLE. One request → Owner = that requester, go to ACCESS. Both requesting → Owner = ~LastGnt (round robin), go to ACCESS.
- ACCESS: MemEn = 1 and MemWe = Owner & DWrite. Load the counter with LATENCY-1. Go to RESP if LATENCY == 1, otherwise go to WAIT.
- WAIT: decrement the counter. Go to RESP on the cycle the counter equals 1.
- RESP: on reads, capture MemRdData into RdData. Register the ack for Owner and set LastGnt = Owner. Go to IDLE.
- AddrSel = Owner. It is registered and holds its value in IDLE until the next grant.
- MemEn and MemWe are decoded from the state register only; they are 0 outside ACCESS.
- Stores leave RdData unchanged but still produce an ack.
- A request that drops mid-transaction is ignored. The transaction completes and the ack still pulses.
- A requester may keep Req high in the ack cycle to start a new transaction. Arbitration in that IDLE cycle applies round robin normally.
- Reset values: state IDLE, Owner 0, LastGnt 1 (the first conflict goes to IF), AddrSel 0, MemEn 0, MemWe 0, IAck 0, DAck 0, RdData 0, counter 0.
- Reset mid-transaction aborts it: no ack is produced, and the next cycle is IDLE with all outputs at reset values.

## Timing
- Request seen in IDLE at cycle t:
  - ACCESS at t+1
  - RESP at t+1+LATENCY
  - Ack and RdData visible at t+2+LATENCY
- Total latency is LATENCY+2 cycles. Back-to-back transactions start every LATENCY+2 cycles, with one IDLE cycle that overlaps the ack.
- Ack is high for exactly one cycle and never to both requesters in the same cycle.
- AddrSel is stable from ACCESS through RESP. External memory samples the address and write data in ACCESS.

## Structure
- Package mem_arb_pkg holds:
  - the state enum (IDLE, ACCESS, WAIT, RESP)
  - OWNER_I = 1'b0, OWNER_D = 1'b1
  - the counter width constant (4 bits)
- Sub-module mem_arb_latency_counter: load, decrement, and a terminal flag (count == 1). Instantiated once.
- The remainder (FSM, arbitration, output registers) lives in mem_port_arbiter.

## Test plan
- Reset: hold Rst 2 cycles with IReq = DReq = 1 → all outputs 0, no MemEn; after release, first grant goes to IF (AddrSel 0).
- Single fetch, LATENCY = 2: IReq at cycle 0, MemRdData = 0x8C010004 in cycle 3 → MemEn in cycle 1 only, IAck = 1 in cycle 4 only, RdData = 0x8C010004, IStall high in cycles 0–3.
- Conflict: IReq = DReq = 1 from cycle 0, both held → IAck at cycle 4 (AddrSel 0); then data granted, AddrSel = 1 from cycle 5, DAck at cycle 8; IF granted again next.
- Store: DReq = 1, DWrite = 1 with RdData = 0x12345678 beforehand → MemWe = 1 only in cycle 1, DAck in cycle 4, RdData still 0x12345678.
- Reset in WAIT (cycle 2) → cycle 3 IDLE, no ack, MemEn 0; the reissued IReq completes normally 4 cycles later.
- LATENCY = 1: IReq at cycle 0 → ACCESS in cycle 1, RESP in cycle 2, IAck in cycle 3.
